// File: rtl/ternary_pkg.sv
// ternary_pkg: shared types, constants and the golden ternary function for
// the ternary pair sequencer.
//   trit_t        2-bit balanced-ternary digit (11=-1, 00=0, 01=+1, 10 illegal)
//   seq_state_t   sequencer FSM states
//   trit_xor      golden classifier function, -(x*y)
//   trit_of_digit maps an unsigned digit 0/1/2 onto the trit -1/0/+1
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_NEG     = 2'b11;
    localparam trit_t TRIT_ZERO    = 2'b00;
    localparam trit_t TRIT_POS     = 2'b01;
    localparam trit_t TRIT_ILLEGAL = 2'b10;

    localparam logic [3:0] LAST_PAIR = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } seq_state_t;

    // -(x*y) for legal trits: zero if either operand is zero, otherwise
    // equal signs give -1 and opposite signs give +1.
    function automatic trit_t trit_xor(trit_t x, trit_t y);
        if (x == TRIT_ZERO || y == TRIT_ZERO) begin
            return TRIT_ZERO;
        end
        return (x == y) ? TRIT_NEG : TRIT_POS;
    endfunction

    function automatic trit_t trit_of_digit(logic [1:0] d);
        case (d)
            2'd0:    return TRIT_NEG;
            2'd1:    return TRIT_ZERO;
            default: return TRIT_POS;
        endcase
    endfunction

endpackage

// File: rtl/txor_watchdog.sv
// txor_watchdog: loadable up-counter with a terminal flag, used to bound the
// time the sequencer waits for a classifier result.
//   clk     rising-edge clock
//   rst     synchronous active-high reset (clears the count)
//   load    clears the count (held while the sequencer is not waiting)
//   run     counts one per cycle while high
//   expired high in the LIMIT-th consecutive run cycle
module txor_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] count;

    // count==k during the (k+1)-th run cycle, so the flag rises in cycle LIMIT
    assign expired = run && (count == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ternary_pair_sequencer.sv
// ternary_pair_sequencer: sweeps all nine (x,y) trit pairs through a
// downstream classifier over ready/valid handshakes and checks every result
// against -(x*y).
//   clk          rising-edge clock
//   rst          synchronous active-high reset, priority over everything
//   start        one-cycle sweep request, ignored while busy
//   pair_valid   / pair_ready / pair_x / pair_y : pair issue handshake
//   res_valid    / res_ready / res_z             : result return handshake
//   busy         high in every state except IDLE
//   done         one-cycle pulse at sweep end
//   err_count    mismatches in the current or last sweep (0..9)
//   mismatch_map bit i set when pair i mismatched or timed out
// Optional feature: define TXOR_SEQ_TIMEOUT_EN to bound WAIT to MAX_WAIT
// cycles; an expired wait counts as a mismatch for that pair.
module ternary_pair_sequencer
    import ternary_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       pair_valid,
    input  logic       pair_ready,
    output logic [1:0] pair_x,
    output logic [1:0] pair_y,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [1:0] res_z,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_count,
    output logic [8:0] mismatch_map
);

    if (MAX_WAIT == 0) begin : g_bad_max_wait
        $error("MAX_WAIT must be at least 1");
    end

    seq_state_t state, next_state;
    logic [3:0] idx;
    trit_t      res_q;
    logic       to_q;
    logic       timeout;
    logic       pair_bad;

`ifdef TXOR_SEQ_TIMEOUT_EN
    txor_watchdog #(
        .LIMIT(MAX_WAIT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (state != ST_WAIT),
        .run    (state == ST_WAIT),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pair_valid = 1'b0;
        res_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        pair_x     = TRIT_ZERO;
        pair_y     = TRIT_ZERO;

        // pair i is (i/3 - 1, i%3 - 1); outputs rest at zero while idle
        if (state != ST_IDLE) begin
            pair_x = trit_of_digit(2'(idx / 4'd3));
            pair_y = trit_of_digit(2'(idx % 4'd3));
        end

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pair_valid = 1'b1;
                if (pair_ready) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                res_ready = 1'b1;
                if (res_valid || timeout) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                next_state = (idx == LAST_PAIR) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign pair_bad = to_q || (res_q == TRIT_ILLEGAL) ||
                      (res_q != trit_xor(pair_x, pair_y));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            res_q        <= TRIT_ZERO;
            to_q         <= 1'b0;
            err_count    <= '0;
            mismatch_map <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx          <= '0;
                        err_count    <= '0;
                        mismatch_map <= '0;
                    end
                end
                ST_WAIT: begin
                    // a result arriving on the expiry cycle still counts
                    if (res_valid) begin
                        res_q <= res_z;
                        to_q  <= 1'b0;
                    end else if (timeout) begin
                        to_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (pair_bad) begin
                        mismatch_map[idx] <= 1'b1;
                        err_count         <= err_count + 4'd1;
                    end
                    if (idx != LAST_PAIR) begin
                        idx <= idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
